flash_bank_ctrl: RTL

FLASH_BANK_CTRL -- requirements
Module: flash_bank_ctrl

---
 rtl/flash_bank_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/flash_bank_ctrl.sv
// Burst read/write controller for a strobed flash bank with a 16-byte write buffer.
// Define READBACK_VERIFY_EN to re-read and compare every written byte (sticky verifyErr).
module flash_bank_ctrl #(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic       cmdWrite,
  input  logic [3:0] cmdBank,
  input  logic [3:0] cmdBlock,
  input  logic [7:0] cmdRow,
  input  logic [3:0] cmdLen,
  input  logic [7:0] wrData,
  input  logic       wrValid,
  output logic       wrReady,
  output logic [7:0] rdData,
  output logic       rdValid,
  input  logic       rdReady,
  inout  wire  [7:0] memData,
  output logic       memReadEnable,
  output logic       memWriteEnable,
  output logic [3:0] memBank,
  output logic [3:0] memBlock,
  output logic [7:0] memRow,
  output logic       busy,
  output logic       verifyErr
);

  localparam logic [3:0] StrobeLast = 4'(STROBE_CYCLES - 1);

`ifdef READBACK_VERIFY_EN
  typedef enum logic [2:0] {
    StIdle, StWload, StWsetup, StWstrobe, StWhold, StVstrobe, StRstrobe, StRpush
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StWload, StWsetup, StWstrobe, StWhold, StRstrobe, StRpush
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [3:0]  bank_q, bank_d;
  logic [3:0]  block_q, block_d;
  logic [7:0]  row_q, row_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [7:0]  buf_q [16];
  logic        buf_we;
  logic        drive_bus;
  logic        last_byte;
  logic        strobe_done;
`ifdef READBACK_VERIFY_EN
  logic        verify_err_q, verify_err_d;
`endif

  assign last_byte   = (idx_q == len_q);
  assign strobe_done = (scnt_q == StrobeLast);

  always_comb begin
    state_d        = state_q;
    bank_d         = bank_q;
    block_d        = block_q;
    row_d          = row_q;
    len_d          = len_q;
    idx_d          = idx_q;
    scnt_d         = scnt_q;
    rd_data_d      = rd_data_q;
`ifdef READBACK_VERIFY_EN
    verify_err_d   = verify_err_q;
`endif
    cmdReady       = 1'b0;
    wrReady        = 1'b0;
    rdValid        = 1'b0;
    memReadEnable  = 1'b1;
    memWriteEnable = 1'b1;
    drive_bus      = 1'b0;
    buf_we         = 1'b0;

    case (state_q)
      StIdle: begin
        cmdReady = 1'b1;
        if (cmdValid) begin
          bank_d  = cmdBank;
          block_d = cmdBlock;
          row_d   = cmdRow;
          len_d   = cmdLen;
          idx_d   = 4'd0;
          scnt_d  = 4'd0;
`ifdef READBACK_VERIFY_EN
          verify_err_d = 1'b0;
`endif
          state_d = cmdWrite ? StWload : StRstrobe;
        end
      end

      // Whole burst is buffered before the bank sees any strobe.
      StWload: begin
        wrReady = 1'b1;
        if (wrValid) begin
          buf_we = 1'b1;
          if (last_byte) begin
            idx_d   = 4'd0;
            state_d = StWsetup;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      StWsetup: begin
        drive_bus = 1'b1;
        scnt_d    = 4'd0;
        state_d   = StWstrobe;
      end

      StWstrobe: begin
        drive_bus      = 1'b1;
        memWriteEnable = 1'b0;
        if (strobe_done) begin
          state_d = StWhold;
        end else begin
          scnt_d = scnt_q + 4'd1;
        end
      end

      StWhold: begin
        drive_bus = 1'b1;
`ifdef READBACK_VERIFY_EN
        scnt_d    = 4'd0;
        state_d   = StVstrobe;
`else
        row_d     = row_q + 8'd1;
        if (last_byte) begin
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StWsetup;
        end
`endif
      end

`ifdef READBACK_VERIFY_EN
      StVstrobe: begin
        memReadEnable = 1'b0;
        if (strobe_done) begin
          if (memData != buf_q[idx_q]) verify_err_d = 1'b1;
          row_d = row_q + 8'd1;
          if (last_byte) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StWsetup;
          end
        end else begin
          scnt_d = scnt_q + 4'd1;
        end
      end
`endif

      StRstrobe: begin
        memReadEnable = 1'b0;
        if (strobe_done) begin
          rd_data_d = memData;
          state_d   = StRpush;
        end else begin
          scnt_d = scnt_q + 4'd1;
        end
      end

      // Next access waits for the consumer so rdData never changes under a stall.
      StRpush: begin
        rdValid = 1'b1;
        if (rdReady) begin
          row_d = row_q + 8'd1;
          if (last_byte) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 4'd1;
            scnt_d  = 4'd0;
            state_d = StRstrobe;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bank_q       <= 4'd0;
      block_q      <= 4'd0;
      row_q        <= 8'd0;
      len_q        <= 4'd0;
      idx_q        <= 4'd0;
      scnt_q       <= 4'd0;
      rd_data_q    <= 8'd0;
`ifdef READBACK_VERIFY_EN
      verify_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      block_q      <= block_d;
      row_q        <= row_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      scnt_q       <= scnt_d;
      rd_data_q    <= rd_data_d;
`ifdef READBACK_VERIFY_EN
      verify_err_q <= verify_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[idx_q] <= wrData;
  end

  assign memData  = drive_bus ? buf_q[idx_q] : 8'bz;
  assign memBank  = bank_q;
  assign memBlock = block_q;
  assign memRow   = row_q;
  assign rdData   = rd_data_q;
  assign busy     = (state_q != StIdle);

`ifdef READBACK_VERIFY_EN
  assign verifyErr = verify_err_q;
`else
  assign verifyErr = 1'b0;
`endif

endmodule
